// File: rtl/fp_arith_pkg.sv
// Shared definitions for the sequential multiply/divide slice.
//   OP_MUL / OP_DIV : operation select encoding
//   state_t         : controller state encoding (IDLE, CALC, FINISH)
//   clog2()         : ceiling log2, usable in constant expressions
package fp_arith_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per cycle, WIDTH iterations per operation; divide by zero
// finishes immediately.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin an operation on op/a/b (ignored while busy)
//   abort           synchronous abort back to IDLE, outputs held
//   op              OP_MUL or OP_DIV
//   a, b            operands (multiplicand/multiplier, dividend/divisor)
//   busy            high while iterating
//   done            one-cycle pulse while the new outputs are presented
//   result          product low half or quotient
//   remainder       divide remainder, 0 after multiply
//   ovf             product high half non-zero
//   div_zero        last divide had divisor 0
module seq_muldiv_core
  import fp_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf,
  output logic             div_zero
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  // hi: upper product half / partial remainder; lo: multiplier / quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] result_d, remainder_d;
  logic             ovf_d, div_zero_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration of whichever algorithm is active.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    // Partial remainder is always < divisor, so the shifted value is below
    // twice the divisor and the subtraction's top bit is a clean borrow.
    div_ge    = ~div_diff[WIDTH];
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opd_d       = opd_q;
    result_d    = result;
    remainder_d = remainder;
    ovf_d       = ovf;
    div_zero_d  = div_zero;
    unique case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start && !abort) begin
          op_d  = op;
          cnt_d = '0;
          if (op == OP_DIV && b == '0) begin
            result_d    = '1;
            remainder_d = a;
            ovf_d       = 1'b0;
            div_zero_d  = 1'b1;
            state_d     = FINISH;
          end else begin
            hi_d    = '0;
            lo_d    = (op == OP_MUL) ? b : a;
            opd_d   = (op == OP_MUL) ? a : b;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          // Outputs load on the last iteration so they are valid alongside done.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d    = FINISH;
            result_d   = step_lo;
            div_zero_d = 1'b0;
            if (op_q == OP_MUL) begin
              remainder_d = '0;
              ovf_d       = |step_hi;
            end else begin
              remainder_d = step_hi;
              ovf_d       = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      result    <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      result    <= result_d;
      remainder <= remainder_d;
      ovf       <= ovf_d;
      div_zero  <= div_zero_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == FINISH);

endmodule

// File: rtl/seq_muldiv_loader.sv
// Operand loader plus sequential unsigned multiply/divide.
// Two WIDTH-bit operands are assembled from CHUNK-bit slices (a first, LS
// slice first, then b); the final slice starts the calculation.
// Ports:
//   CLOCK_50   system clock, rising edge
//   reset_n    asynchronous active-low reset
//   load       one-cycle load strobe (edge-detected upstream)
//   load_data  operand slice captured on load
//   op_sel     0 = multiply, 1 = divide; sampled on the final load
//   clear      synchronous abort of loading/calculation
//   load_idx   index of the next slice to be accepted
//   busy       calculation in progress
//   done       one-cycle pulse when outputs update
//   result     product low half or quotient
//   remainder  divide remainder, 0 after multiply
//   ovf        multiply overflow (high half non-zero)
//   div_zero   last divide had divisor 0
module seq_muldiv_loader
  import fp_arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CHUNK  = 16,
  parameter int unsigned NCHUNK = WIDTH / CHUNK
) (
  input  logic                             CLOCK_50,
  input  logic                             reset_n,
  input  logic                             load,
  input  logic [CHUNK-1:0]                 load_data,
  input  logic                             op_sel,
  input  logic                             clear,
  output logic [clog2(2*NCHUNK)-1:0]       load_idx,
  output logic                             busy,
  output logic                             done,
  output logic [WIDTH-1:0]                 result,
  output logic [WIDTH-1:0]                 remainder,
  output logic                             ovf,
  output logic                             div_zero
);

  localparam int unsigned IDXW = clog2(2 * NCHUNK);

  if (WIDTH < 4) begin : g_bad_width
    $error("seq_muldiv_loader: WIDTH must be at least 4");
  end
  if ((WIDTH % CHUNK) != 0 || NCHUNK != WIDTH / CHUNK) begin : g_bad_chunk
    $error("seq_muldiv_loader: WIDTH must be a multiple of CHUNK, NCHUNK derived");
  end

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_d, b_d;
  logic             accept;
  logic             final_load;

  assign accept     = load && !busy && !clear;
  assign final_load = accept && (load_idx == IDXW'(2 * NCHUNK - 1));

  // Operand registers with the current slice merged in. The core takes b_d
  // directly so the final slice reaches it in the same cycle it is loaded.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (load_idx == IDXW'(i))          a_d[i*CHUNK +: CHUNK] = load_data;
      if (load_idx == IDXW'(i + NCHUNK)) b_d[i*CHUNK +: CHUNK] = load_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      load_idx <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (clear) begin
      load_idx <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (accept) begin
      a_q      <= a_d;
      b_q      <= b_d;
      load_idx <= final_load ? '0 : load_idx + IDXW'(1);
    end
  end

  seq_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .start     (final_load),
    .abort     (clear),
    .op        (op_sel),
    .a         (a_q),
    .b         (b_d),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .ovf       (ovf),
    .div_zero  (div_zero)
  );

endmodule

// File: doc/seq_muldiv_loader.md
Name: seq_muldiv_loader

Overview:
- Parametrised successor to the board-level integer mul/div block.
- Assembles two WIDTH-bit operands from CHUNK-bit slices, then runs an iterative shift-add multiply or restoring divide.
- Uses a start/busy/done handshake and reports status flags.
- Sits between the switch/key front end (debounce and edge detect are upstream) and the hex/LED display logic.

Parameters:
- WIDTH, 32: operand and result width. Must be ≥ 4.
- CHUNK, 16: bits supplied per load strobe. WIDTH % CHUNK must equal 0, checked by an elaboration-time assertion.
- NCHUNK, WIDTH/CHUNK: derived; do not override.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle load strobe, already edge-detected.
- load_data  in  CHUNK  operand slice captured on load.
- op_sel  in  1  0 = multiply, 1 = divide. Sampled only on the final load strobe.
- clear  in  1  synchronous abort; active-high, one cycle.
- load_idx  out  clog2(2*NCHUNK)  index of the next slice to be accepted.
- busy  out  1  high while a calculation is in progress.
- done  out  1  one-cycle pulse when result, remainder and flags update.
- result  out  WIDTH  product low half, or quotient.
- remainder  out  WIDTH  divide remainder; 0 after a multiply.
- ovf  out  1  multiply: product high half is non-zero.
- div_zero  out  1  last divide had divisor 0.

Behaviour:
- Reset (async, reset_n = 0): every register and output is 0; state IDLE.
- Slice order: load_idx 0..NCHUNK-1 fills operand a, least-significant slice first. Indices NCHUNK..2*NCHUNK-1 fill b the same way.
- Load acceptance:
  - A load is accepted only when busy = 0; load_idx then increments.
  - Load while busy = 1 is ignored. No slice is captured and load_idx is unchanged.
- Final load:
  - Accepted in cycle T at index 2*NCHUNK-1.
  - Captures a, b (including the final slice) and op_sel.
  - Resets load_idx to 0 and enters CALC at T+1.
- States:
  - IDLE: waiting or accumulating slices.
  - CALC: iterating; busy = 1.
  - FINISH: writes outputs; done = 1 for exactly one cycle, busy = 0. Returns to IDLE on the next cycle.
- Multiply:
  - WIDTH iterations, one per cycle, in cycles T+1..T+WIDTH; 2*WIDTH-bit accumulator.
  - FINISH at T+WIDTH+1: result = product[WIDTH-1:0], ovf = |product[2W-1:W], remainder = 0, div_zero = 0.
- Divide, b ≠ 0:
  - Restoring division, WIDTH iterations, same timing as multiply.
  - result = a / b, remainder = a % b, ovf = 0, div_zero = 0.
- Divide, b = 0:
  - No iterations; FINISH at T+1.
  - result = all ones, remainder = a, div_zero = 1, ovf = 0.
- Between done pulses: result, remainder, ovf and div_zero hold their values; the next FINISH overwrites all four.
- clear:
  - Next cycle: state IDLE, load_idx 0, busy 0, no done pulse.
  - Partial operands are discarded; result and flags keep their last values.
  - clear takes priority over a simultaneous load.
- reset_n asserted mid-CALC: immediate abort, all outputs 0.
- All arithmetic is unsigned.
- Final load and clear in the same cycle: clear wins and no calculation starts.

Decomposition:
- Shared package fp_arith_pkg:
  - op encoding constants OP_MUL = 1'b0, OP_DIV = 1'b1;
  - state enum IDLE/CALC/FINISH;
  - a clog2 helper function.
- One sub-module, seq_muldiv_core (parametrised by WIDTH):
  - ports start, op, a, b → busy, done, result, remainder, ovf, div_zero;
  - contains the iteration counter and datapath.
- The top level owns slice assembly, load_idx and clear.

Test Plan:
- WIDTH=32, CHUNK=16. Load 0x0003, 0x0000, 0x0005, 0x0000 with op_sel=0 → done at T+33 with result=0x0000000F, ovf=0, remainder=0.
- Load a=0x00010000, b=0x00010000, multiply → result=0x00000000, ovf=1.
- Divide a=100, b=7 → done at T+33 with result=14, remainder=2, div_zero=0.
- Divide a=0x12345678, b=0 → done at T+1 with result=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
- Start a multiply and pulse load five times while busy → load_idx stays 0, operands unchanged, result correct. Separately, clear after 2 slices → load_idx=0, and the next 4 loads compute correctly.
- Assert reset_n=0 at T+10 of a divide → all outputs 0 immediately, no done pulse. Also re-run scenarios 1–4 with WIDTH=16, CHUNK=8: done at T+17, same values truncated to 16 bits.
